// File: rtl/fifo_uart_tx.sv
// FIFO drain + async serial transmitter: pops one byte per frame and sends start, 8 data bits LSB first, stop bit(s).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] baud_reg, baud_next;
    logic [2:0]  bit_reg, bit_next;
    logic        stop_reg, stop_next;
    logic [7:0]  shift_reg, shift_next;
`ifdef FIFO_UART_TX_PARITY_EN
    logic        parity_reg, parity_next;
`endif
    logic        tx_reg, tx_next;
    logic        rd_en_reg, rd_en_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        baud_last;

    assign baud_last = (baud_reg == BAUD_LAST);

    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        stop_next   = stop_reg;
        shift_next  = shift_reg;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                // FIFO read data is valid only in this cycle
                shift_next  = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_next = ^fifo_data;
`endif
                baud_next   = 16'd0;
                state_next  = START;
            end
            START: begin
                if (baud_last) begin
                    baud_next  = 16'd0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next  = 16'd0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        stop_next  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_next  = 16'd0;
                    stop_next  = 1'b0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_next = 16'd0;
                    if (stop_reg == STOP_LAST) begin
                        stop_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        stop_next = stop_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
        rd_en_next = (state_next == FETCH);
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == STOP) && (baud_next == BAUD_LAST) && (stop_next == STOP_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            baud_reg   <= 16'd0;
            bit_reg    <= 3'd0;
            stop_reg   <= 1'b0;
            shift_reg  <= 8'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
            tx_reg     <= 1'b1;
            rd_en_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            stop_reg   <= stop_next;
            shift_reg  <= shift_next;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
            tx_reg     <= tx_next;
            rd_en_reg  <= rd_en_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign tx         = tx_reg;
    assign fifo_rd_en = rd_en_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (1 and 2 stop bits) fed from byte-FIFO models, checked every cycle
// against a frame-level reference built from the fetch time and the byte value.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_en = 1'b0;
    logic       fifo_empty [2];
    logic [7:0] fifo_data [2];
    logic       fifo_rd_en [2];
    logic       tx [2];
    logic       busy [2];
    logic       frame_done [2];

    logic [7:0] fmem [2][256];
    int         tail [2];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", tag, inst, cyc, obs, exp);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_ch
            localparam int SB = gi + 1;
            localparam int FL = CPB * (10 + PAR + SB - 1);
            int         head = 0;
            logic [7:0] rd_data = 8'h00;
            int         f_at = -1000;
            int         busy_until = -1;
            logic [7:0] fb = 8'h00;

            assign fifo_empty[gi] = (head == tail[gi]);
            assign fifo_data[gi]  = rd_data;

            fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) u_dut (
                .clk        (clk),
                .reset      (reset),
                .tx_en      (tx_en),
                .fifo_empty (fifo_empty[gi]),
                .fifo_data  (fifo_data[gi]),
                .fifo_rd_en (fifo_rd_en[gi]),
                .tx         (tx[gi]),
                .busy       (busy[gi]),
                .frame_done (frame_done[gi])
            );

            // FIFO model: data appears the cycle after a read, zero otherwise
            always @(posedge clk) begin
                if (fifo_rd_en[gi] && head != tail[gi]) begin
                    rd_data <= fmem[gi][head % 256];
                    head    <= head + 1;
                end else begin
                    rd_data <= 8'h00;
                end
            end

            // Reference: frame fetched at f_at, start bit two cycles later, FL cycles long
            always @(negedge clk) begin : mdl
                int   k;
                int   b;
                logic e_tx;
                if (reset) begin
                    f_at       = -1000;
                    busy_until = -1;
                    check_eq("rst_tx", gi, 32'(tx[gi]), 1);
                    check_eq("rst_busy", gi, 32'(busy[gi]), 0);
                    check_eq("rst_rd", gi, 32'(fifo_rd_en[gi]), 0);
                end else begin
                    k    = cyc - (f_at + 2);
                    e_tx = 1'b1;
                    if (k >= 0 && k < FL) begin
                        b = k / CPB;
                        if (b == 0) e_tx = 1'b0;
                        else if (b <= 8) e_tx = fb[b-1];
                        else if (PAR == 1 && b == 9) e_tx = ^fb;
                    end
                    check_eq("tx", gi, 32'(tx[gi]), 32'(e_tx));
                    check_eq("rd_en", gi, 32'(fifo_rd_en[gi]), 32'(cyc == f_at));
                    check_eq("busy", gi, 32'(busy[gi]), 32'(cyc >= f_at && cyc <= busy_until));
                    check_eq("done", gi, 32'(frame_done[gi]), 32'(cyc == busy_until));
                    if (cyc > busy_until && tx_en && head != tail[gi]) begin
                        f_at       = cyc + 1;
                        fb         = fmem[gi][head % 256];
                        busy_until = cyc + FL + 2;
                    end
                end
            end
        end
    endgenerate

    task automatic push(input logic [7:0] d);
        for (int i = 0; i < 2; i++) begin
            fmem[i][tail[i] % 256] = d;
            tail[i] = tail[i] + 1;
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            if (fifo_empty[0] && fifo_empty[1] && !busy[0] && !busy[1]) ok = 1;
        end
        check_eq("idle_timeout", 0, 32'(ok), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_rd();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (fifo_rd_en[0]) ok = 1;
        end
        check_eq("rd_timeout", 0, 32'(ok), 1);
    endtask

    initial begin
        tail[0] = 0;
        tail[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tx_en = 1'b1;
        repeat (50) @(posedge clk);
        #1;

        push(8'hA5);
        wait_idle();
        push(8'h01);
        push(8'h80);
        wait_idle();

        // tx_en dropped mid-DATA: current frame finishes, queued byte stays put
        push(8'h3C);
        push(8'h55);
        wait_rd();
        repeat (10) @(posedge clk);
        #1;
        tx_en = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check_eq("held", 0, 32'(tail[0] - gen_ch[0].head), 1);
        check_eq("held", 1, 32'(tail[1] - gen_ch[1].head), 1);
        tx_en = 1'b1;
        wait_idle();

        push(8'hFF);
        push(8'h01);
        wait_idle();

        // Reset during DATA: outputs must go idle without waiting for a clock
        push(8'h96);
        wait_rd();
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("async_tx", i, 32'(tx[i]), 1);
            check_eq("async_busy", i, 32'(busy[i]), 0);
            check_eq("async_rd", i, 32'(fifo_rd_en[i]), 0);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_idle();

        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 99) == 0) tx_en = ~tx_en;
            if ($urandom_range(0, 14) == 0 && (tail[0] - gen_ch[0].head) < 16 && (tail[1] - gen_ch[1].head) < 16)
                push(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
            end
        end
        tx_en = 1'b1;
        wait_idle();
        for (int i = 0; i < 2; i++) begin
            check_eq("end_tx", i, 32'(tx[i]), 1);
            check_eq("end_busy", i, 32'(busy[i]), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
